// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data memory responder for the data-cache request path.
// Optional DATA_MEM_STATS_EN adds saturating completed read/write counters.
module data_mem_responder #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 64,
  parameter int LATENCY = 5
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] address,
  input  logic [ADDR_W-1:0] writedata,
  output logic              requested_data_to_mem,
  output logic [ADDR_W-1:0] readdata,
  output logic              readdata_valid,
  output logic              err
`ifdef DATA_MEM_STATS_EN
  ,output logic [15:0]      rd_count,
  output logic [15:0]       wr_count
`endif
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]        state;
  logic [CNT_W-1:0]  counter;
  logic              op_wr;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] wdata;
  logic [ADDR_W-1:0] mem [DEPTH];

  logic req, legal, done;

  assign req   = mem_read | mem_write;
  // Legal: exactly one op, word aligned, word index inside the array.
  assign legal = (mem_read ^ mem_write) && (address[1:0] == 2'b00) &&
                 (address[ADDR_W-1:IDX_W+2] == '0);
  assign done  = (state == BUSY) && (counter == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                 <= IDLE;
      requested_data_to_mem <= 1'b0;
      readdata              <= '0;
      readdata_valid        <= 1'b0;
      err                   <= 1'b0;
      counter               <= '0;
      op_wr                 <= 1'b0;
      idx                   <= '0;
      wdata                 <= '0;
    end else begin
      readdata_valid <= 1'b0;
      err            <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              state                 <= BUSY;
              requested_data_to_mem <= 1'b1;
              counter               <= CNT_W'(LATENCY - 1);
              op_wr                 <= mem_write;
              idx                   <= address[IDX_W+1:2];
              wdata                 <= writedata;
            end else begin
              err <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            state                 <= IDLE;
            requested_data_to_mem <= 1'b0;
            if (!op_wr) begin
              readdata       <= mem[idx];
              readdata_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is deliberately unreset; reset forces IDLE so a pending write never lands.
  always_ff @(posedge clk) begin
    if (done && op_wr) mem[idx] <= wdata;
  end

`ifdef DATA_MEM_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (done) begin
      if (op_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      if (!op_wr && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder against an array/queue reference model.
module tb_data_mem_responder;
  localparam int ADDR_W  = 32;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              mem_read = 1'b0, mem_write = 1'b0;
  logic [ADDR_W-1:0] address = '0, writedata = '0;
  logic              requested_data_to_mem, readdata_valid, err;
  logic [ADDR_W-1:0] readdata;
`ifdef DATA_MEM_STATS_EN
  logic [15:0]       rd_count, wr_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {bit is_err; logic [31:0] data;} exp_t;
  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] last_rd = 32'd0;
  int          n_rd = 0, n_wr = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .writedata(writedata),
    .requested_data_to_mem(requested_data_to_mem), .readdata(readdata),
    .readdata_valid(readdata_valid), .err(err)
`ifdef DATA_MEM_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset && (readdata_valid || err)) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", {30'd0, err, readdata_valid}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_kind", {30'd0, err, readdata_valid}, mon_e.is_err ? 32'd2 : 32'd1);
        if (!mon_e.is_err) chk("readdata", readdata, mon_e.data);
      end
    end
  end

  task automatic clear_in();
    mem_read = 1'b0; mem_write = 1'b0; address = '0; writedata = '0;
  endtask

  // Called at a negedge; returns at a negedge with inputs idle.
  task automatic access(bit rd, bit wr, logic [31:0] a, logic [31:0] d, bit hold);
    bit legal = (rd != wr) && (a % 4 == 0) && (a / 4 < DEPTH);
    int cnt = 0;
    mem_read = rd; mem_write = wr; address = a; writedata = d;
    if (!legal && (rd || wr)) sbq.push_back('{1'b1, 32'd0});
    else if (legal && rd)     sbq.push_back('{1'b0, model_mem[a / 4]});
    @(posedge clk);
    if (legal) begin
      do begin
        @(negedge clk);
        if (!hold) clear_in();
        if (requested_data_to_mem) cnt++;
      end while (requested_data_to_mem && cnt < 50);
      chk("busy_cycles", cnt, LATENCY);
      if (wr) begin
        model_mem[a / 4] = d;
        n_wr++;
        chk("readdata_hold", readdata, last_rd);
      end else begin
        last_rd = model_mem[a / 4];
        n_rd++;
      end
    end else begin
      @(negedge clk);
      chk("no_busy", {31'd0, requested_data_to_mem}, 32'd0);
    end
    clear_in();
  endtask

  task automatic check_stats();
`ifdef DATA_MEM_STATS_EN
    chk("rd_count", {16'd0, rd_count}, n_rd);
    chk("wr_count", {16'd0, wr_count}, n_wr);
`endif
  endtask

  initial begin
    #1;
    chk("rst_busy",  {31'd0, requested_data_to_mem}, 32'd0);
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_valid", {31'd0, readdata_valid}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    check_stats();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < DEPTH; i++) access(1'b0, 1'b1, i * 4, $urandom, 1'b0);

    // Directed: write then read back 0x10.
    access(1'b0, 1'b1, 32'h10, 32'h81, 1'b0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("rd_0x10", readdata, 32'h81);
    // Held read is serviced once; next request accepted right after busy falls.
    access(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    access(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    // Rejected requests.
    access(1'b1, 1'b1, 32'h04, 32'hDEAD, 1'b0);
    access(1'b1, 1'b0, 32'h04, 32'h0, 1'b0);
    access(1'b1, 1'b0, 32'h06, 32'h0, 1'b0);
    access(1'b0, 1'b1, 32'h100, 32'h5, 1'b0);

    // Reset in the third busy cycle of a write to 0x20.
    mem_write = 1'b1; address = 32'h20; writedata = 32'h381;
    @(posedge clk);
    @(negedge clk); clear_in();
    @(negedge clk);
    @(negedge clk);
    chk("busy_before_rst", {31'd0, requested_data_to_mem}, 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_busy",  {31'd0, requested_data_to_mem}, 32'd0);
    chk("midrst_rdata", readdata, 32'd0);
    chk("midrst_valid", {31'd0, readdata_valid}, 32'd0);
    last_rd = 32'd0; n_rd = 0; n_wr = 0;
    check_stats();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0);

    // Counter scenario: 3 writes, 2 reads (one above), 1 rejected.
    access(1'b0, 1'b1, 32'h08, 32'h11, 1'b0);
    access(1'b0, 1'b1, 32'h0C, 32'h22, 1'b0);
    access(1'b0, 1'b1, 32'h08, 32'h33, 1'b0);
    access(1'b1, 1'b0, 32'h08, 32'h0, 1'b0);
    access(1'b1, 1'b1, 32'h08, 32'h0, 1'b0);
    check_stats();

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int kind = $urandom_range(0, 9);
      logic [31:0] a = $urandom_range(0, DEPTH - 1) * 4;
      logic [31:0] d = $urandom;
      bit h = $urandom_range(0, 1);
      case (kind)
        0, 1, 2: access(1'b0, 1'b1, a, d, h);
        3, 4, 5: access(1'b1, 1'b0, a, d, h);
        6:       access(1'b1, 1'b1, a, d, h);
        7:       access(1'b1, 1'b0, a + $urandom_range(1, 3), d, h);
        8:       access(1'b0, 1'b1, 32'h100 + a + ($urandom_range(0, 255) << 8), d, h);
        default: access(1'b0, 1'b0, a, d, h);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_stats();

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
